// File: rtl/clk_rst_sequencer.sv
// Lock-qualified reset sequencer plus NUM_CH phase-programmable clock-enable strobes.
// lock_s lags pll_locked by 2 edges; rst_out/ready/ce decode from registers; no backpressure.
module clk_rst_sequencer #(
    parameter int NUM_CH             = 2,
    parameter int DIV_W              = 8,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RST_HOLD_CYCLES    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic [NUM_CH*DIV_W-1:0]   cfg_div,
    input  logic [NUM_CH*DIV_W-1:0]   cfg_phase,
    input  logic                      cfg_load,
    output logic [NUM_CH-1:0]         ce,
    output logic                      rst_out,
    output logic                      ready,
    output logic [7:0]                lock_loss_count
);

    typedef enum logic [1:0] {ST_WAIT, ST_STABLE, ST_HOLD, ST_RUN} state_t;

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                     : RST_HOLD_CYCLES;
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             lock_s_q, lock_s_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] fsm_cnt_q, fsm_cnt_d;
    logic [7:0]       loss_q, loss_d;
    logic             enter_run;

    logic [DIV_W-1:0]  div_q    [NUM_CH];
    logic [DIV_W-1:0]  div_d    [NUM_CH];
    logic [DIV_W-1:0]  phase_q  [NUM_CH];
    logic [DIV_W-1:0]  phase_d  [NUM_CH];
    logic [DIV_W-1:0]  pdiv_q   [NUM_CH];
    logic [DIV_W-1:0]  pdiv_d   [NUM_CH];
    logic [DIV_W-1:0]  pphase_q [NUM_CH];
    logic [DIV_W-1:0]  pphase_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [DIV_W-1:0]  deff_cur [NUM_CH];
    logic [DIV_W-1:0]  deff_nxt [NUM_CH];
    logic [DIV_W-1:0]  phase_nxt[NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ce_c;

    always_comb begin
        sync1_d   = pll_locked;
        lock_s_d  = sync1_q;
        state_d   = state_q;
        fsm_cnt_d = fsm_cnt_q;
        loss_d    = loss_q;
        case (state_q)
            ST_WAIT: begin
                if (lock_s_q) begin
                    state_d   = ST_STABLE;
                    fsm_cnt_d = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d   = ST_WAIT;
                    fsm_cnt_d = '0;
                end else if (fsm_cnt_q == STABLE_LAST) begin
                    state_d   = ST_HOLD;
                    fsm_cnt_d = '0;
                end else begin
                    fsm_cnt_d = fsm_cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s_q) begin
                    state_d   = ST_WAIT;
                    fsm_cnt_d = '0;
                    loss_d    = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end else if (fsm_cnt_q == HOLD_LAST) begin
                    state_d   = ST_RUN;
                    fsm_cnt_d = '0;
                end else begin
                    fsm_cnt_d = fsm_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d   = ST_WAIT;
                    fsm_cnt_d = '0;
                    loss_d    = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_WAIT;
                fsm_cnt_d = '0;
            end
        endcase
    end

    assign enter_run = (state_q != ST_RUN) && (state_d == ST_RUN);

    // Pending registers always track the most recent cfg_load, so copying them back
    // into the active set on lock loss never resurrects a stale configuration.
    always_comb begin
        pend_d = pend_q;
        ce_c   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]    = div_q[i];
            phase_d[i]  = phase_q[i];
            pdiv_d[i]   = pdiv_q[i];
            pphase_d[i] = pphase_q[i];
            cnt_d[i]    = cnt_q[i];
            deff_cur[i] = (div_q[i] == '0) ? DIV_W'(1) : div_q[i];
            ce_c[i]     = (state_q == ST_RUN) && (cnt_q[i] == deff_cur[i] - DIV_W'(1));
            if (state_q != ST_RUN) begin
                if (cfg_load) begin
                    div_d[i]    = cfg_div[i*DIV_W +: DIV_W];
                    phase_d[i]  = cfg_phase[i*DIV_W +: DIV_W];
                    pdiv_d[i]   = cfg_div[i*DIV_W +: DIV_W];
                    pphase_d[i] = cfg_phase[i*DIV_W +: DIV_W];
                end
            end else begin
                if (ce_c[i]) begin
                    cnt_d[i] = '0;
                    if (pend_q[i]) begin
                        div_d[i]  = pdiv_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
                if (cfg_load) begin
                    pdiv_d[i]   = cfg_div[i*DIV_W +: DIV_W];
                    pphase_d[i] = cfg_phase[i*DIV_W +: DIV_W];
                    pend_d[i]   = 1'b1;
                end
                if (state_d != ST_RUN) begin
                    div_d[i]   = pdiv_d[i];
                    phase_d[i] = pphase_d[i];
                    pend_d[i]  = 1'b0;
                end
            end
            // Entry phase is taken from the configuration that is active in RUN.
            deff_nxt[i]  = (div_d[i] == '0) ? DIV_W'(1) : div_d[i];
            phase_nxt[i] = (phase_d[i] >= deff_nxt[i]) ? '0 : phase_d[i];
            if (enter_run) begin
                cnt_d[i] = phase_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            state_q   <= ST_WAIT;
            fsm_cnt_q <= '0;
            loss_q    <= '0;
            pend_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]    <= '0;
                phase_q[i]  <= '0;
                pdiv_q[i]   <= '0;
                pphase_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            lock_s_q  <= lock_s_d;
            state_q   <= state_d;
            fsm_cnt_q <= fsm_cnt_d;
            loss_q    <= loss_d;
            pend_q    <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]    <= div_d[i];
                phase_q[i]  <= phase_d[i];
                pdiv_q[i]   <= pdiv_d[i];
                pphase_q[i] <= pphase_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign ce              = ce_c;
    assign rst_out         = (state_q != ST_RUN);
    assign ready           = (state_q == ST_RUN);
    assign lock_loss_count = loss_q;

endmodule

// File: doc/clk_rst_sequencer.md
# clk_rst_sequencer

Lock-qualified reset sequencer and multi-channel clock-enable generator, one clock domain. Sits directly behind the board PLL wrapper: it synchronises and debounces the PLL `locked` flag, holds the downstream reset through a programmable stabilisation window, and then produces `NUM_CH` phase-programmable clock-enable strobes. Slow logic runs off one PLL clock through these strobes instead of extra PLL outputs. Lock loss is detected, counted, and forces the whole sequence back to reset.

## Interface
- `NUM_CH`, 2: number of clock-enable channels.
- `DIV_W`, 8: width of each channel's divisor and phase fields.
- `LOCK_STABLE_CYCLES`, 16: consecutive synchronised-lock cycles required before reset hold begins (≥1).
- `RST_HOLD_CYCLES`, 8: cycles `rst_out` stays high after lock is qualified (≥1).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  raw PLL lock flag, asynchronous; passes through a 2-flop synchroniser to give `lock_s`.
- `cfg_div`  in  NUM_CH*DIV_W  per-channel divisor; channel i uses bits [i*DIV_W +: DIV_W].
- `cfg_phase`  in  NUM_CH*DIV_W  per-channel initial phase, same packing.
- `cfg_load`  in  1  one-cycle strobe that captures `cfg_div` and `cfg_phase` for all channels.
- `ce`  out  NUM_CH  clock-enable strobes, one cycle wide.
- `rst_out`  out  1  downstream reset, active-high.
- `ready`  out  1  high only in RUN.
- `lock_loss_count`  out  8  count of lock losses after qualification; saturates at 255.

## Operation
- FSM states and transitions:
  - WAIT: goes to STABLE when `lock_s`=1.
  - STABLE: counts `lock_s`-high cycles. `lock_s`=0 returns to WAIT with no count increment. Goes to HOLD after exactly `LOCK_STABLE_CYCLES` cycles in STABLE.
  - HOLD: goes to RUN after exactly `RST_HOLD_CYCLES` cycles.
  - RUN: stays until `lock_s`=0.
  - From HOLD or RUN, `lock_s`=0 moves to WAIT and increments `lock_loss_count`, saturating at 255.
  - Every state change clears the FSM cycle counter.
- Outputs decoded from the state register:
  - `rst_out` = (state != RUN).
  - `ready` = (state == RUN).
  - `ce` = 0 in every state except RUN.
- Channel i divisor:
  - d_eff = `cfg_div` value, except 0 is treated as 1.
  - Phase values ≥ d_eff are treated as 0.
- Channel i counter:
  - The counter is loaded with the active phase on the cycle the FSM enters RUN.
  - In each RUN cycle, `ce[i]` = (cnt == d_eff-1).
  - The counter then updates: cnt <= `ce[i]` ? 0 : cnt+1.
- Configuration outside RUN: `cfg_load` writes the active div/phase registers directly.
- Configuration in RUN:
  - `cfg_load` writes a per-channel pending register and sets a pending flag.
  - At that channel's next `ce` cycle, the pending div becomes active, the counter restarts at 0, and the flag clears.
  - The pending phase is stored and used at the next RUN entry.
- Simultaneous events:
  - `cfg_load` on a channel's `ce` cycle: that `ce` applies the previously pending value, if any. The new value stays pending until the following `ce`.
  - A second `cfg_load` before the apply overwrites the pending value.
  - `lock_s`=0 in RUN: the pending flags are discarded, and the pending values are copied into the active registers.

## Timing
- Reset values, effective after the `rst`-high edge:
  - state WAIT, all counters 0, synchroniser flops 0.
  - Active and pending config registers 0, pending flags 0.
  - `rst_out`=1, `ready`=0, `ce`=0, `lock_loss_count`=0.
- `rst` mid-sequence (any state) overrides everything on that edge, including an in-progress lock loss increment.
- Lock-up latency:
  - Count edge 1 as the first edge sampling `pll_locked`=1.
  - STABLE is entered after edge 3.
  - RUN is entered, with `ready`=1 and `rst_out`=0, after edge 3+L+H. With defaults that is edge 27.
- Lock-loss latency:
  - Count edge 1 as the first edge sampling `pll_locked`=0.
  - The FSM is in WAIT after edge 3.
  - `rst_out`=1, `ce`=0, and the count has incremented in that same cycle.
- A lock glitch shorter than 1 clock may be missed by the synchroniser. That is acceptable.
- First `ce[i]` falls in RUN cycle (d_eff-1-phase), counting the first RUN cycle as 0. Period thereafter is d_eff cycles.

## Test plan
- Lock-up: defaults, `pll_locked` 0→1 and held -> `rst_out` falls and `ready` rises after edge 27. `ce`=0 before that.
- Dividers: ch0 div=4 phase=0, ch1 div=3 phase=2, then lock -> ch0 `ce` in RUN cycles 3, 7, 11; ch1 `ce` in cycles 0, 3, 6.
- Degenerate config: div=0 and div=1 -> `ce` high every RUN cycle. div=4 phase=9 -> behaves as phase 0.
- Debounce: `pll_locked` high for 10 cycles then low, during STABLE -> returns to WAIT, `lock_loss_count` stays 0, `ready` never rises.
- Lock loss in RUN: drop `pll_locked` -> `rst_out`=1 after edge 3, count=1. Repeat 300 times -> count saturates at 255.
- Reconfig in RUN: div 4→6 via `cfg_load` mid-period -> old period completes, and the next strobes arrive 6 cycles apart. Assert `rst` mid-RUN -> all outputs return to reset values on the next edge.
